stream_uart_tx: RTL and testbench

//   Buffered AXI-Stream byte sink to UART transmitter: next generation of the score emitter path.

---
 rtl/stream_uart_pkg.sv | 20 ++
 rtl/stream_fifo.sv | 51 +++++
 rtl/stream_uart_tx.sv | 195 +++++++++++++++++++
 tb/tb_stream_uart_tx.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/stream_uart_pkg.sv
// Shared types and helpers for the stream-to-UART transmitter.
package stream_uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_GAP
    } state_t;

    // Bit period in core clocks, rounded to the nearest integer.
    function automatic int clk_div_f(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO with extra pointer MSB for full/empty, async active-high reset.
// Read data is presented combinationally from the head entry.
module stream_fifo #(
    parameter int WIDTH = 9,
    parameter int AW    = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    localparam int DEPTH = 2 ** AW;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr_en;
    logic             w_rd_en;

    assign w_wr_en = i_wr && !o_full;
    assign w_rd_en = i_rd && !o_empty;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

    // Storage array: no reset needed, validity tracked by the pointers.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

    // Pointer update; simultaneous read and write are both honoured.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/stream_uart_tx.sv
// Buffered AXI-Stream byte sink driving a UART TX line (8N1, LSB first).
// After a tlast byte the line is held idle for GAP_BITS extra bit periods.
// Optional macro UART_PARITY_EN adds an even parity bit (8E1).
module stream_uart_tx
    import stream_uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 16_000_000,
    parameter int BAUD        = 57_600,
    parameter int FIFO_AW     = 4,
    parameter int GAP_BITS    = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_tdata,
    input  logic       i_tlast,
    input  logic       i_tvalid,
    output logic       o_tready,
    output logic       o_uart_tx,
    output logic       o_busy,
    output logic       o_frame_done
);

    localparam int CLK_DIV = clk_div_f(CLK_FREQ_HZ, BAUD);
    localparam int BAUD_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_MAX = (GAP_BITS > DATA_BITS) ? GAP_BITS : DATA_BITS;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
    localparam logic              HAS_GAP   = (GAP_BITS > 0);

    if (CLK_DIV < 2) begin : g_bad_div
        $error("stream_uart_tx: CLK_DIV must be at least 2");
    end

    state_t             r_state;
    logic [BAUD_W-1:0]  r_baud;
    logic [CNT_W-1:0]   r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_last;
    logic               r_tx;
    logic               r_busy;
    logic               r_frame_done;
`ifdef UART_PARITY_EN
    logic               r_par;
`endif

    logic               w_wr;
    logic               w_rd;
    logic               w_full;
    logic               w_empty;
    logic [8:0]         w_rdata;
    logic [FIFO_AW:0]   w_count;
    logic [FIFO_AW:0]   w_cnt_next;
    logic               w_bit_end;
    logic               w_leave;
    logic               w_idle_next;

    assign o_tready     = !w_full && !i_rst;
    assign w_wr         = i_tvalid && o_tready;
    assign o_uart_tx    = r_tx;
    assign o_busy       = r_busy;
    assign o_frame_done = r_frame_done;

    stream_fifo #(
        .WIDTH (9),
        .AW    (FIFO_AW)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_wr    (w_wr),
        .i_wdata ({i_tlast, i_tdata}),
        .i_rd    (w_rd),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // End of the current bit period.
    assign w_bit_end = (r_baud == BAUD_LAST);

    // Frame fully finished this cycle: stop bit (no gap due) or last gap bit ends.
    assign w_leave = w_bit_end &&
                     ((r_state == S_STOP && !(r_last && HAS_GAP)) ||
                      (r_state == S_GAP  && r_bit_idx == GAP_LAST));

    // Pop whenever the FSM is ready for a new character and one is queued.
    assign w_rd        = !w_empty && (r_state == S_IDLE || w_leave);
    assign w_idle_next =  w_empty && (r_state == S_IDLE || w_leave);
    assign w_cnt_next  = w_count + (FIFO_AW+1)'(w_wr) - (FIFO_AW+1)'(w_rd);

    // Busy reflects next-cycle occupancy so it lines up with the FSM/FIFO state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_busy <= 1'b0;
        else       r_busy <= !w_idle_next || (w_cnt_next != '0);
    end

    // Transmit FSM: bit timing, serialisation, gap and frame-done pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_baud       <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_last       <= 1'b0;
            r_tx         <= 1'b1;
            r_frame_done <= 1'b0;
`ifdef UART_PARITY_EN
            r_par        <= 1'b0;
`endif
        end else begin
            r_frame_done <= 1'b0;
            // Counter wraps at each bit end; every non-IDLE transition happens there.
            r_baud <= w_bit_end ? '0 : r_baud + BAUD_W'(1);
            case (r_state)
                S_IDLE: begin
                    r_baud <= '0;
                    r_tx   <= 1'b1;
                    if (w_rd) begin
                        r_shift <= w_rdata[7:0];
                        r_last  <= w_rdata[8];
`ifdef UART_PARITY_EN
                        r_par   <= ^w_rdata[7:0];
`endif
                        r_state <= S_START;
                        r_tx    <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state   <= S_DATA;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == DATA_LAST) begin
`ifdef UART_PARITY_EN
                            r_state <= S_PARITY;
                            r_tx    <= r_par;
`else
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + CNT_W'(1);
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                        end
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
                    end
                end
`endif
                S_STOP, S_GAP: begin
                    if (w_bit_end && r_state == S_STOP && r_last && HAS_GAP) begin
                        r_state   <= S_GAP;
                        r_bit_idx <= '0;
                        r_tx      <= 1'b1;
                    end else if (w_leave) begin
                        r_frame_done <= r_last;
                        if (w_rd) begin
                            // Chain straight into the next start bit, no idle cycle.
                            r_shift <= w_rdata[7:0];
                            r_last  <= w_rdata[8];
`ifdef UART_PARITY_EN
                            r_par   <= ^w_rdata[7:0];
`endif
                            r_state <= S_START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_tx    <= 1'b1;
                        end
                    end else if (w_bit_end && r_state == S_GAP) begin
                        r_bit_idx <= r_bit_idx + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_uart_tx.sv
`timescale 1ns/1ps
module tb_stream_uart_tx;

    localparam int DIV = 16;
    localparam int GAP = 2;
`ifdef UART_PARITY_EN
    localparam int FBITS = 11;
`else
    localparam int FBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] i_tdata = '0;
    logic       i_tlast = 1'b0;
    logic       i_tvalid = 1'b0;
    logic       o_tready, o_uart_tx, o_busy, o_frame_done;

    stream_uart_tx #(
        .CLK_FREQ_HZ (16_000_000),
        .BAUD        (1_000_000),
        .FIFO_AW     (2),
        .GAP_BITS    (GAP)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_tdata      (i_tdata),
        .i_tlast      (i_tlast),
        .i_tvalid     (i_tvalid),
        .o_tready     (o_tready),
        .o_uart_tx    (o_uart_tx),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [7:0] d; logic l; int acc; } beat_t;
    beat_t q[$];
    int    fdq[$];
    int    n_cmp = 0, n_fail = 0;
    int    prev_end = 0;
    bit    mon_busy = 0;
    bit    bp_seen = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Line monitor: decodes each frame and checks it against the queued beat.
    int    m_s, m_exp_s, m_fr = 0;
    logic  m_smp [FBITS*DIV];
    logic  m_eb  [FBITS];
    bit    m_abort;
    logic  m_got;
    beat_t m_e;
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && o_uart_tx === 1'b0) begin
                mon_busy = 1;
                m_s      = cyc;
                m_abort  = 0;
                m_smp[0] = o_uart_tx;
                for (int i = 1; i < FBITS*DIV; i++) begin
                    @(negedge clk);
                    if (rst !== 1'b0) m_abort = 1;
                    m_smp[i] = o_uart_tx;
                end
                if (m_abort) begin
                    prev_end = 0;
                    fdq.delete();
                end else if (q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_frame: start at cycle %0d, none expected", m_s);
                end else begin
                    m_e     = q.pop_front();
                    m_exp_s = (m_e.acc + 1 > prev_end) ? m_e.acc + 1 : prev_end;
                    chk($sformatf("frame%0d_start_cycle", m_fr), m_s, m_exp_s);
                    m_eb[0] = 1'b0;
                    for (int i = 0; i < 8; i++) m_eb[1+i] = m_e.d[i];
`ifdef UART_PARITY_EN
                    m_eb[9] = ^m_e.d;
`endif
                    m_eb[FBITS-1] = 1'b1;
                    for (int k = 0; k < FBITS; k++) begin
                        m_got = m_eb[k];
                        for (int j = 0; j < DIV; j++)
                            if (m_smp[k*DIV+j] !== m_eb[k]) m_got = m_smp[k*DIV+j];
                        chk($sformatf("frame%0d_byte%02h_bit%0d", m_fr, m_e.d, k), m_got, m_eb[k]);
                    end
                    prev_end = m_s + FBITS*DIV + (m_e.l ? GAP*DIV : 0);
                    if (m_e.l) fdq.push_back(m_s + FBITS*DIV + GAP*DIV);
                    m_fr++;
                end
                mon_busy = 0;
            end
        end
    end

    // Frame-done monitor: every pulse must match a tlast frame's gap end.
    always @(negedge clk) begin
        if (rst === 1'b0 && o_frame_done === 1'b1) begin
            if (fdq.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_frame_done: pulse at cycle %0d, none expected", cyc);
            end else begin
                chk("frame_done_cycle", cyc, fdq.pop_front());
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        int w = 0;
        @(negedge clk);
        i_tdata = d; i_tlast = l; i_tvalid = 1'b1;
        #1;
        while (!o_tready && w < 3000) begin
            bp_seen = 1;
            @(negedge clk); #1;
            w++;
        end
        if (!o_tready) begin
            n_cmp++; n_fail++;
            $display("FAIL send_timeout: tready stuck low, byte %02h", d);
            i_tvalid = 1'b0;
            return;
        end
        q.push_back('{d, l, cyc + 1});
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        i_tvalid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int w = 0;
        idle(0);
        while ((q.size() != 0 || mon_busy) && w < 20000) begin
            @(negedge clk);
            w++;
        end
        chk({name, "_drain_left"}, q.size(), 0);
        repeat (GAP*DIV + 8) @(negedge clk);
        chk({name, "_busy_idle"}, o_busy, 1'b0);
        chk({name, "_tx_idle"}, o_uart_tx, 1'b1);
        chk({name, "_frame_done_pending"}, fdq.size(), 0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx", o_uart_tx, 1'b1);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_frame_done", o_frame_done, 1'b0);
        chk("rst_tready", o_tready, 1'b0);
        rst = 1'b0;
        #1 chk("post_rst_tready", o_tready, 1'b1);

        // Single byte, then two back-to-back bytes.
        send(8'hA5, 1'b0);
        drain("single");
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        drain("b2b");

        // Burst longer than the FIFO with tvalid held high.
        bp_seen = 0;
        for (int i = 0; i < 6; i++) send(8'h10 + 8'(i), 1'b0);
        chk("burst_backpressure", bp_seen, 1'b1);
        drain("burst");

        // tlast followed by another byte, then a lone tlast byte.
        send(8'h55, 1'b1);
        send(8'h66, 1'b0);
        drain("gap");
        send(8'h3C, 1'b1);
        drain("lone_last");

        // Randomised beats with random spacing.
        for (int i = 0; i < 24; i++) begin
            send(8'($urandom), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 200));
        end
        drain("random");

        // Reset in the middle of data bit 3 of 0x00.
        send(8'h00, 1'b0);
        idle(0);
        for (int w = 0; w < 100 && !mon_busy; w++) @(negedge clk);
        chk("rst_test_started", mon_busy, 1'b1);
        repeat (DIV*4 + 4) @(negedge clk);
        chk("rst_test_tx_low_before", o_uart_tx, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_tx", o_uart_tx, 1'b1);
        chk("midrst_tready", o_tready, 1'b0);
        chk("midrst_busy", o_busy, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        q.delete();
        #1 chk("midrst_post_tready", o_tready, 1'b1);
        repeat (300) @(negedge clk);
        chk("midrst_post_tx", o_uart_tx, 1'b1);
        chk("midrst_post_busy", o_busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
